// File: rtl/rs_alu_if.sv
// Shared packet type and the issue/CDB/execute-facing bus of the ALU reservation station.
// The issue stage (or bench) drives the master side; the station is the slave.
package rs_alu_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [4:0]      dest_reg;
        logic [3:0]      alu_func;
    } ID_EX_PACKET;
endpackage

interface rs_alu_if #(parameter int TAG_W = rs_alu_pkg::ROB_TAG_LEN);
    import rs_alu_pkg::*;

    logic                 alloc_en;
    ID_EX_PACKET          alloc_packet;
    logic [TAG_W-1:0]     alloc_rob_tag;
    logic [TAG_W-1:0]     alloc_rs1_tag;
    logic [TAG_W-1:0]     alloc_rs2_tag;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [XLEN-1:0]      cdb_value;
    logic                 flush;
    logic                 ex_ready;
    logic                 issue_valid;
    ID_EX_PACKET          issue_packet;
    logic [TAG_W-1:0]     issue_rob_tag;
    logic                 rs_alu_full;

    modport master (
        output alloc_en, alloc_packet, alloc_rob_tag, alloc_rs1_tag, alloc_rs2_tag,
        output cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
        input  issue_valid, issue_packet, issue_rob_tag, rs_alu_full
    );

    modport slave (
        input  alloc_en, alloc_packet, alloc_rob_tag, alloc_rs1_tag, alloc_rs2_tag,
        input  cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
        output issue_valid, issue_packet, issue_rob_tag, rs_alu_full
    );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: holds decoded ops until both operand tags clear,
// snoops the CDB for missing operands and dispatches the lowest-index ready entry.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = 4,
    parameter int TAG_W   = ROB_TAG_LEN
) (
    input  logic    clock,
    input  logic    reset,
    rs_alu_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic        [RS_SIZE-1:0]            r_valid;
    ID_EX_PACKET                          r_pkt [RS_SIZE];
    logic        [RS_SIZE-1:0][TAG_W-1:0] r_rob;
    logic        [RS_SIZE-1:0][TAG_W-1:0] r_tag1;
    logic        [RS_SIZE-1:0][TAG_W-1:0] r_tag2;

    logic [RS_SIZE-1:0] w_ready;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any_ready;
    logic               w_full;
    logic               w_cdb_hit;
    logic               w_alloc;
    logic               w_dispatch;
    ID_EX_PACKET        w_alloc_pkt;
    logic [TAG_W-1:0]   w_alloc_t1;
    logic [TAG_W-1:0]   w_alloc_t2;

    assign w_full     = &r_valid;
    assign w_cdb_hit  = bus.cdb_valid && (bus.cdb_tag != '0);
    assign w_alloc    = bus.alloc_en && !w_full && !bus.flush;
    assign w_dispatch = w_any_ready && bus.ex_ready;

    // Readiness looks only at registered tags; a same-cycle CDB match waits a cycle.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++)
            w_ready[i] = r_valid[i] && (r_tag1[i] == '0) && (r_tag2[i] == '0);
    end

    always_comb begin
        w_free_idx  = '0;
        w_sel_idx   = '0;
        w_any_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i])
                w_free_idx = IDX_W'(i);
            if (w_ready[i]) begin
                w_sel_idx   = IDX_W'(i);
                w_any_ready = 1'b1;
            end
        end
    end

    // Operand bypass when the producer broadcasts in the allocation cycle.
    always_comb begin
        w_alloc_pkt = bus.alloc_packet;
        w_alloc_t1  = bus.alloc_rs1_tag;
        w_alloc_t2  = bus.alloc_rs2_tag;
        if (w_cdb_hit && (bus.alloc_rs1_tag == bus.cdb_tag)) begin
            w_alloc_pkt.rs1_value = bus.cdb_value;
            w_alloc_t1            = '0;
        end
        if (w_cdb_hit && (bus.alloc_rs2_tag == bus.cdb_tag)) begin
            w_alloc_pkt.rs2_value = bus.cdb_value;
            w_alloc_t2            = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_rob   <= '0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            for (int i = 0; i < RS_SIZE; i++)
                r_pkt[i] <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_valid[i] && w_cdb_hit && (r_tag1[i] == bus.cdb_tag)) begin
                    r_pkt[i].rs1_value <= bus.cdb_value;
                    r_tag1[i]          <= '0;
                end
                if (r_valid[i] && w_cdb_hit && (r_tag2[i] == bus.cdb_tag)) begin
                    r_pkt[i].rs2_value <= bus.cdb_value;
                    r_tag2[i]          <= '0;
                end
                // The allocation slot is free, so it can never be the dispatched one.
                if (bus.flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_alloc && (w_free_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_pkt[i]   <= w_alloc_pkt;
                    r_rob[i]   <= bus.alloc_rob_tag;
                    r_tag1[i]  <= w_alloc_t1;
                    r_tag2[i]  <= w_alloc_t2;
                end else if (w_dispatch && (w_sel_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.issue_valid   = w_any_ready;
    assign bus.issue_packet  = w_any_ready ? r_pkt[w_sel_idx] : '0;
    assign bus.issue_rob_tag = w_any_ready ? r_rob[w_sel_idx] : '0;
    assign bus.rs_alu_full   = w_full;
endmodule

// File: tb/tb_rs_alu.sv
// Directed plan plus random traffic against an entry-array reference model of the station.
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_alu_if #(.TAG_W(TW)) bus ();
    rs_alu #(.RS_SIZE(N), .TAG_W(TW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int n_prot = 0;

    bit          m_v   [N];
    ID_EX_PACKET m_pkt [N];
    logic [TW-1:0] m_rob [N];
    logic [TW-1:0] m_t1  [N];
    logic [TW-1:0] m_t2  [N];

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_sel();
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_t1[i] == 0 && m_t2[i] == 0) return i;
        return -1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < N; i++)
            if (!m_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Applies the inputs that were present at the edge to the pre-edge model state.
    task automatic model_step();
        int sel, fr;
        bit full, hit;
        ID_EX_PACKET p;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_pkt[i] = '0; m_rob[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
            end
            return;
        end
        sel  = m_sel();
        full = m_full();
        fr   = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        hit = bus.cdb_valid && bus.cdb_tag != 0;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && hit && m_t1[i] == bus.cdb_tag) begin
                m_pkt[i].rs1_value = bus.cdb_value; m_t1[i] = 0;
            end
            if (m_v[i] && hit && m_t2[i] == bus.cdb_tag) begin
                m_pkt[i].rs2_value = bus.cdb_value; m_t2[i] = 0;
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
        end else begin
            if (sel >= 0 && bus.ex_ready) m_v[sel] = 0;
            if (bus.alloc_en && full) begin
                n_prot++;
            end else if (bus.alloc_en) begin
                p = bus.alloc_packet;
                m_t1[fr] = bus.alloc_rs1_tag;
                m_t2[fr] = bus.alloc_rs2_tag;
                if (hit && bus.alloc_rs1_tag == bus.cdb_tag) begin p.rs1_value = bus.cdb_value; m_t1[fr] = 0; end
                if (hit && bus.alloc_rs2_tag == bus.cdb_tag) begin p.rs2_value = bus.cdb_value; m_t2[fr] = 0; end
                m_v[fr]   = 1;
                m_pkt[fr] = p;
                m_rob[fr] = bus.alloc_rob_tag;
            end
        end
    endtask

    task automatic check_model();
        int sel = m_sel();
        chk("m_valid", 160'(bus.issue_valid), 160'(sel >= 0));
        chk("m_full",  160'(bus.rs_alu_full), 160'(m_full()));
        chk("m_rob",   160'(bus.issue_rob_tag), (sel >= 0) ? 160'(m_rob[sel]) : 160'(0));
        chk("m_pkt",   160'(bus.issue_packet),  (sel >= 0) ? 160'(m_pkt[sel]) : 160'(0));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle();
        bus.alloc_en = 0; bus.alloc_packet = '0; bus.alloc_rob_tag = 0;
        bus.alloc_rs1_tag = 0; bus.alloc_rs2_tag = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.flush = 0;
    endtask

    task automatic drv_alloc(input int rob, input int t1, input int t2);
        bus.alloc_en = 1;
        bus.alloc_rob_tag = TW'(rob);
        bus.alloc_rs1_tag = TW'(t1);
        bus.alloc_rs2_tag = TW'(t2);
        bus.alloc_packet.pc        = $urandom;
        bus.alloc_packet.inst      = $urandom;
        bus.alloc_packet.rs1_value = $urandom;
        bus.alloc_packet.rs2_value = $urandom;
        bus.alloc_packet.dest_reg  = 5'($urandom);
        bus.alloc_packet.alu_func  = 4'($urandom);
    endtask

    initial begin
        reset = 1; bus.ex_ready = 1; idle();
        tick(); tick();
        reset = 0;
        chk("rst_valid", 160'(bus.issue_valid), 160'(0));
        chk("rst_full",  160'(bus.rs_alu_full), 160'(0));
        chk("rst_rob",   160'(bus.issue_rob_tag), 160'(0));
        chk("rst_pkt",   160'(bus.issue_packet), 160'(0));

        // ADDI with both operands present
        drv_alloc(3, 0, 0); tick(); idle();
        chk("addi_valid", 160'(bus.issue_valid), 160'(1));
        chk("addi_rob",   160'(bus.issue_rob_tag), 160'(3));
        tick();
        chk("addi_gone",  160'(bus.issue_valid), 160'(0));

        // ADD waiting on tag 2, woken by CDB two cycles later
        drv_alloc(5, 2, 0); tick(); idle();
        chk("add_wait", 160'(bus.issue_valid), 160'(0));
        tick();
        bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_value = 32'h1234;
        chk("add_nowake", 160'(bus.issue_valid), 160'(0));
        tick(); idle();
        chk("add_valid", 160'(bus.issue_valid), 160'(1));
        chk("add_rs1",   160'(bus.issue_packet.rs1_value), 160'(32'h1234));
        tick();

        // CDB bypass in the allocation cycle
        drv_alloc(4, 0, 2);
        bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_value = 32'hBEEF;
        tick(); idle();
        chk("byp_valid", 160'(bus.issue_valid), 160'(1));
        chk("byp_rs2",   160'(bus.issue_packet.rs2_value), 160'(32'hBEEF));
        tick();

        // Fill all entries on tag 7, overflow alloc, then drain in order
        for (int k = 1; k <= 4; k++) begin drv_alloc(k, 7, 0); tick(); end
        idle();
        chk("fill_full", 160'(bus.rs_alu_full), 160'(1));
        drv_alloc(9, 0, 0); tick(); idle();
        chk("ovf_full",  160'(bus.rs_alu_full), 160'(1));
        chk("ovf_ign",   160'(bus.issue_valid), 160'(0));
        bus.cdb_valid = 1; bus.cdb_tag = 7; bus.cdb_value = 32'h77;
        tick(); idle();
        for (int k = 1; k <= 4; k++) begin
            chk("drain_rob",  160'(bus.issue_rob_tag), 160'(k));
            chk("drain_full", 160'(bus.rs_alu_full), 160'(k == 1));
            tick();
        end
        chk("drain_done", 160'(bus.issue_valid), 160'(0));

        // Back-pressure holds the selected entry
        bus.ex_ready = 0;
        drv_alloc(6, 0, 0); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", 160'(bus.issue_valid), 160'(1));
            chk("hold_rob",   160'(bus.issue_rob_tag), 160'(6));
            tick();
        end
        bus.ex_ready = 1;
        tick();
        chk("hold_once", 160'(bus.issue_valid), 160'(0));

        // Flush overrides a same-cycle allocation
        for (int k = 1; k <= 3; k++) begin drv_alloc(k, 7, 0); tick(); end
        idle();
        drv_alloc(8, 0, 0); bus.flush = 1;
        tick(); idle();
        chk("fl_valid", 160'(bus.issue_valid), 160'(0));
        chk("fl_full",  160'(bus.rs_alu_full), 160'(0));
        drv_alloc(9, 0, 0); tick(); idle();
        chk("fl_rob",   160'(bus.issue_rob_tag), 160'(9));
        chk("fl_slot0", 160'(dut.r_valid), 160'(4'b0001));
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            drv_alloc($urandom_range(1, 15),
                      ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3));
            bus.alloc_en  = ($urandom_range(0, 1) != 0);
            bus.cdb_valid = ($urandom_range(0, 1) != 0);
            bus.cdb_tag   = TW'($urandom_range(0, 3));
            bus.cdb_value = $urandom;
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.ex_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 0; idle();
        $display("note: %0d alloc attempts while full were ignored", n_prot);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
